// File: rtl/ok_axi_pkg.sv
// Shared definitions for the FrontPanel AXI4-Lite register bank: response codes,
// channel FSM encodings and a small sizing helper.
package ok_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ok_axi4lite_addr_decode.sv
// Word-index decoder: RW control window first, RO status window next, the rest unmapped.
module ok_axi4lite_addr_decode
    import ok_axi_pkg::*;
#(
    parameter int IDX_W    = 10,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_is_rw,
    output logic             o_is_ro,
    output logic             o_is_unmapped,
    output logic [SEL_W-1:0] o_sel_index
);

    // One extra bit so 2*NUM_REGS can equal the full index space without wrapping.
    localparam logic [IDX_W:0] NUM_RW  = (IDX_W+1)'(NUM_REGS);
    localparam logic [IDX_W:0] NUM_ALL = (IDX_W+1)'(2 * NUM_REGS);

    logic [IDX_W:0] w_idx_ext;
    assign w_idx_ext = {1'b0, i_idx};

    // NOTE: every output gets a default before the if-chain so no latch is inferred.
    always_comb begin
        o_is_rw       = 1'b0;
        o_is_ro       = 1'b0;
        o_is_unmapped = 1'b0;
        o_sel_index   = '0;
        if (w_idx_ext < NUM_RW) begin
            o_is_rw     = 1'b1;
            o_sel_index = SEL_W'(w_idx_ext);
        end else if (w_idx_ext < NUM_ALL) begin
            o_is_ro     = 1'b1;
            o_sel_index = SEL_W'(w_idx_ext - NUM_RW);
        end else begin
            o_is_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/ok_axi4lite_register_bank.sv
// AXI4-Lite slave exposing NUM_REGS RW control registers (with per-write pulses)
// and NUM_REGS RO status words; write and read channels run independently.
module ok_axi4lite_register_bank
    import ok_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                         okClkIn,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [WORD_BYTES-1:0]        s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH*NUM_REGS-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]          ctrl_wr_pulse,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] status_in
);

    localparam int IDX_W = ADDR_WIDTH - $clog2(WORD_BYTES);
    localparam int SEL_W = sel_width(NUM_REGS);

    wr_state_e r_wr_state, w_wr_state_nxt;
    rd_state_e r_rd_state, w_rd_state_nxt;

    logic [DATA_WIDTH-1:0] r_ctrl [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_status [NUM_REGS];

    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WORD_BYTES-1:0] r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data, w_rd_data;
    logic [WORD_BYTES-1:0] w_wr_strb;
    logic [1:0]            w_rd_resp;
    logic                  w_wr_rw, w_wr_ro, w_wr_unmapped;
    logic                  w_rd_rw, w_rd_ro, w_rd_unmapped;
    logic [SEL_W-1:0]      w_wr_sel, w_rd_sel;
    logic                  w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{w_wr_addr[1:0], s_axi_araddr[1:0], w_rd_unmapped};

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_regs[DATA_WIDTH*i +: DATA_WIDTH] = r_ctrl[i];
            w_status[i] = status_in[DATA_WIDTH*i +: DATA_WIDTH];
        end
    end

    // A beat handshaking this cycle counts as held, so the commit needs no extra cycle.
    assign w_aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_w_hs      = s_axi_wvalid & s_axi_wready;
    assign w_wr_addr   = r_aw_held ? r_awaddr : s_axi_awaddr;
    assign w_wr_data   = r_w_held ? r_wdata : s_axi_wdata;
    assign w_wr_strb   = r_w_held ? r_wstrb : s_axi_wstrb;
    assign w_wr_commit = (r_wr_state == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    ok_axi4lite_addr_decode #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_wr_decode (
        .i_idx         (w_wr_addr[ADDR_WIDTH-1:2]),
        .o_is_rw       (w_wr_rw),
        .o_is_ro       (w_wr_ro),
        .o_is_unmapped (w_wr_unmapped),
        .o_sel_index   (w_wr_sel)
    );

    ok_axi4lite_addr_decode #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_rd_decode (
        .i_idx         (s_axi_araddr[ADDR_WIDTH-1:2]),
        .o_is_rw       (w_rd_rw),
        .o_is_ro       (w_rd_ro),
        .o_is_unmapped (w_rd_unmapped),
        .o_sel_index   (w_rd_sel)
    );

    always_ff @(posedge okClkIn) begin
        if (rst) r_wr_state <= W_IDLE;
        else     r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE: if (w_wr_commit)  w_wr_state_nxt = W_RESP;
            W_RESP: if (s_axi_bready) w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (r_wr_state == W_IDLE) & ~r_aw_held & ~rst;
        s_axi_wready  = (r_wr_state == W_IDLE) & ~r_w_held & ~rst;
        s_axi_bvalid  = (r_wr_state == W_RESP);
    end

    assign s_axi_bresp   = r_bresp;
    assign ctrl_wr_pulse = r_wr_pulse;

    always_ff @(posedge okClkIn) begin
        if (rst) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            // NOTE: the control registers are architectural state visible to fabric, so the
            // whole array is cleared on reset rather than left as an unreset memory.
            for (int i = 0; i < NUM_REGS; i++) r_ctrl[i] <= '0;
        end else begin
            // NOTE: non-blocking default then a later override; the last <= in the block wins.
            r_wr_pulse <= '0;
            if (w_wr_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                if (w_wr_rw) begin
                    for (int b = 0; b < WORD_BYTES; b++) begin
                        if (w_wr_strb[b]) r_ctrl[w_wr_sel][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                    r_wr_pulse[w_wr_sel] <= 1'b1;
                    r_bresp <= RESP_OKAY;
                end else if (w_wr_ro) begin
                    r_bresp <= RESP_SLVERR;
                end else if (w_wr_unmapped) begin
                    r_bresp <= RESP_DECERR;
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_axi_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axi_wdata;
                    r_wstrb  <= s_axi_wstrb;
                end
            end
        end
    end

    assign w_ar_hs = s_axi_arvalid & s_axi_arready;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_DECERR;
        if (w_rd_rw) begin
            w_rd_data = r_ctrl[w_rd_sel];
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_ro) begin
            w_rd_data = w_status[w_rd_sel];
            w_rd_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge okClkIn) begin
        if (rst) r_rd_state <= R_IDLE;
        else     r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE: if (w_ar_hs)      w_rd_state_nxt = R_DATA;
            R_DATA: if (s_axi_rready) w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (r_rd_state == R_IDLE) & ~rst;
        s_axi_rvalid  = (r_rd_state == R_DATA);
    end

    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rresp;

    always_ff @(posedge okClkIn) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

endmodule

// File: tb/tb_ok_axi4lite_register_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic scored against an
// address-map model of the register bank.
module tb_ok_axi4lite_register_bank;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              okClkIn = 1'b0;
    logic              rst;
    logic [AW-1:0]     s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DW-1:0]     s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW-1:0]     s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [DW*NR-1:0]  ctrl_regs;
    logic [NR-1:0]     ctrl_wr_pulse;
    logic [DW*NR-1:0]  status_in;

    always #5 okClkIn = ~okClkIn;

    ok_axi4lite_register_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .okClkIn       (okClkIn),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .status_in     (status_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_ctrl   [NR];
    logic [31:0] m_status [NR];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge okClkIn);
        #1;
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] r = '0;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = m_ctrl[i];
        return r;
    endfunction

    // Address map: words 0..NR-1 control, NR..2NR-1 status, everything else unmapped.
    task automatic model_read(input logic [11:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(addr) / 4;
        if (idx < NR) begin
            d = m_ctrl[idx]; r = 2'b00;
        end else if (idx < 2 * NR) begin
            d = m_status[idx - NR]; r = 2'b00;
        end else begin
            d = 32'h0; r = 2'b11;
        end
    endtask

    task automatic model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NR-1:0] pulse);
        int idx = int'(addr) / 4;
        logic [31:0] mask = '0;
        pulse = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        if (idx < NR) begin
            m_ctrl[idx] = (m_ctrl[idx] & ~mask) | (data & mask);
            pulse = NR'(1) << idx;
            resp = 2'b00;
        end else if (idx < 2 * NR) begin
            resp = 2'b10;
        end else begin
            resp = 2'b11;
        end
    endtask

    // stall < 0 leaves the response pending; otherwise bready is withheld for 'stall' cycles.
    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int stall);
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse;
        bit aw_done = 0, w_done = 0, aw_fire, w_fire, early = 0;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axi_awaddr  = addr;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            if (s_axi_bvalid) early = 1;
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("wr_handshake", 512'(aw_done && w_done), 512'(1));
        check("bvalid_early", 512'(early), 512'(0));
        model_write(addr, data, strb, exp_resp, exp_pulse);
        check("bvalid", 512'(s_axi_bvalid), 512'(1));
        check("bresp", 512'(s_axi_bresp), 512'(exp_resp));
        check("wr_pulse", 512'(ctrl_wr_pulse), 512'(exp_pulse));
        check("ctrl_regs", ctrl_regs, model_flat());
        if (stall < 0) return;
        tick();
        check("wr_pulse_drop", 512'(ctrl_wr_pulse), 512'(0));
        check("b_hold", 512'({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready}),
              512'({1'b1, exp_resp, 2'b00}));
        for (int i = 1; i < stall; i++) begin
            tick();
            check("b_hold", 512'({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready}),
                  512'({1'b1, exp_resp, 2'b00}));
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bvalid_clear", 512'(s_axi_bvalid), 512'(0));
    endtask

    task automatic do_read(input logic [11:0] addr, input int stall);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        bit ar_done = 0, ar_fire;
        int cyc = 0;
        model_read(addr, exp_d, exp_r);
        while (!ar_done && cyc < 40) begin
            s_axi_araddr  = addr;
            s_axi_arvalid = 1'b1;
            ar_fire = s_axi_arready;
            tick();
            if (ar_fire) ar_done = 1;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        check("ar_handshake", 512'(ar_done), 512'(1));
        check("rvalid", 512'(s_axi_rvalid), 512'(1));
        check("rdata", 512'(s_axi_rdata), 512'(exp_d));
        check("rresp", 512'(s_axi_rresp), 512'(exp_r));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("r_hold", 512'({s_axi_rvalid, s_axi_rresp, s_axi_rdata, s_axi_arready}),
                  512'({1'b1, exp_r, exp_d, 1'b0}));
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("rvalid_clear", 512'(s_axi_rvalid), 512'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0]   old_d, new_d;
        logic [1:0]    old_r, exp_b;
        logic [NR-1:0] exp_p;

        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_ctrl[i]   = 32'h0;
            m_status[i] = $urandom;
        end
        m_status[2] = 32'h12345678;
        for (int i = 0; i < NR; i++) status_in[32*i +: 32] = m_status[i];

        // Reset state
        tick(); tick();
        check("rst_ready", 512'({s_axi_awready, s_axi_wready, s_axi_arready}), 512'(0));
        check("rst_valid", 512'({s_axi_bvalid, s_axi_rvalid}), 512'(0));
        check("rst_resp_data", 512'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 512'(0));
        check("rst_ctrl", ctrl_regs, 512'(0));
        check("rst_pulse", 512'(ctrl_wr_pulse), 512'(0));
        rst = 1'b0;
        tick();
        check("idle_ready", 512'({s_axi_awready, s_axi_wready, s_axi_arready}), 512'(3'b111));

        // Full write, AW and W together, then read back
        do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 1);
        do_read(12'h004, 0);

        // W leads AW by 3 cycles, partial strobes
        do_write(12'h008, 32'hAABBCCDD, 4'hF, 0, 0, 1);
        do_write(12'h008, 32'h11223344, 4'h5, 3, 0, 2);
        check("strb_merge", 512'(ctrl_regs[64 +: 32]), 512'(32'hAA22CC44));
        // AW leads W, strobe zero still pulses
        do_write(12'h00C, 32'hCAFEF00D, 4'h0, 0, 2, 1);

        // Status window and unmapped space
        do_read(12'h048, 1);
        do_write(12'h048, 32'h55555555, 4'hF, 0, 0, 1);
        do_read(12'h080, 0);
        do_write(12'hFFC, 32'h77777777, 4'hF, 1, 0, 1);

        // Concurrent read and write of the same register with both responses stalled
        model_read(12'h004, old_d, old_r);
        new_d = 32'h0BADC0DE;
        s_axi_awaddr = 12'h004; s_axi_wdata = new_d; s_axi_wstrb = 4'hF;
        s_axi_araddr = 12'h004;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        check("cc_ready", 512'({s_axi_awready, s_axi_wready, s_axi_arready}), 512'(3'b111));
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        model_write(12'h004, new_d, 4'hF, exp_b, exp_p);
        check("cc_pulse", 512'(ctrl_wr_pulse), 512'(exp_p));
        for (int i = 0; i < 5; i++) begin
            check("cc_stall", 512'({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata,
                                   s_axi_awready, s_axi_wready, s_axi_arready}),
                  512'({1'b1, 1'b1, exp_b, old_r, old_d, 3'b000}));
            tick();
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("cc_clear", 512'({s_axi_bvalid, s_axi_rvalid}), 512'(0));
        check("cc_ctrl", ctrl_regs, model_flat());

        // Randomized traffic across mapped and unmapped words
        for (int n = 0; n < 30; n++) begin
            logic [11:0] wa, ra;
            int widx = $urandom_range(0, 2 * NR + 3);
            int ridx = $urandom_range(0, 2 * NR + 3);
            if (n % 10 == 9) widx = 1023;
            wa = 12'(widx * 4 + int'($urandom_range(0, 3)));
            ra = 12'(ridx * 4 + int'($urandom_range(0, 3)));
            do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(1, 3));
            do_read(ra, $urandom_range(0, 2));
        end

        // Reset while a write response is pending
        do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, -1);
        rst = 1'b1;
        tick();
        check("rst_mid_bvalid", 512'(s_axi_bvalid), 512'(0));
        check("rst_mid_ctrl", ctrl_regs, 512'(0));
        check("rst_mid_ready", 512'({s_axi_awready, s_axi_wready}), 512'(0));
        rst = 1'b0;
        for (int i = 0; i < NR; i++) m_ctrl[i] = 32'h0;
        tick();
        do_read(12'h004, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
